// File: rtl/axioma_io_pkg.sv
// Shared types and constants for the axioma I/O fabric and its interrupt arbiter.
package axioma_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } fsm_state_e;

    localparam int IRQ_VEC_W = 6;
    localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/axioma_io_fabric_if.sv
// Core-side request bus and peripheral-slot bus of the axioma I/O fabric.
interface axioma_io_fabric_if #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8
) ();

    logic [ADDR_W-1:0]          m_addr;
    logic [DATA_W-1:0]          m_wdata;
    logic                       m_read;
    logic                       m_write;
    logic [DATA_W-1:0]          m_rdata;
    logic                       m_ready;
    logic                       m_error;

    logic [N_SLAVES-1:0]        s_sel;
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_wdata;
    logic                       s_read;
    logic                       s_write;
    logic [N_SLAVES*DATA_W-1:0] s_rdata;
    logic [N_SLAVES-1:0]        s_ready;

    // master: the core plus the peripherals surrounding the fabric
    modport master (
        output m_addr, m_wdata, m_read, m_write, s_rdata, s_ready,
        input  m_rdata, m_ready, m_error, s_sel, s_addr, s_wdata, s_read, s_write
    );

    // slave: the fabric itself
    modport slave (
        input  m_addr, m_wdata, m_read, m_write, s_rdata, s_ready,
        output m_rdata, m_ready, m_error, s_sel, s_addr, s_wdata, s_read, s_write
    );

endinterface

// File: rtl/axioma_irq_arbiter.sv
// Rising-edge interrupt latching with a lowest-index-first vector and acknowledge clear.
module axioma_irq_arbiter
    import axioma_io_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_IRQ-1:0]     irq_src,
    input  logic                 irq_ack,
    output logic                 irq_req,
    output logic [IRQ_VEC_W-1:0] irq_vector,
    output logic [N_IRQ-1:0]     irq_pending
);

    logic [N_IRQ-1:0]     hist_q;
    logic [N_IRQ-1:0]     pending_q, pending_d;
    logic [N_IRQ-1:0]     edge_det;
    logic [N_IRQ-1:0]     ack_mask;
    logic [IRQ_VEC_W-1:0] vec_q, vec_d;
    logic                 req_q;

    assign edge_det = irq_src & ~hist_q;

    // A vector of 0 matches no bit, so an acknowledge with nothing pending is a no-op.
    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_ack
            assign ack_mask[gi] = irq_ack && (vec_q == IRQ_VEC_W'(gi + 1));
        end
    endgenerate

    // Edge is OR-ed after the clear so a coincident edge keeps the bit pending.
    assign pending_d = (pending_q & ~ack_mask) | edge_det;

    always_comb begin
        vec_d = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                vec_d = IRQ_VEC_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q    <= '0;
            pending_q <= '0;
            vec_q     <= '0;
            req_q     <= 1'b0;
        end else begin
            hist_q    <= irq_src;
            pending_q <= pending_d;
            vec_q     <= vec_d;
            req_q     <= |pending_q;
        end
    end

    assign irq_req     = req_q;
    assign irq_vector  = vec_q;
    assign irq_pending = pending_q;

endmodule

// File: rtl/axioma_io_fabric.sv
// Core I/O port to N peripheral slots: window decode, wait-state handshake with timeout,
// registered read data, bus errors, plus the interrupt arbiter.
module axioma_io_fabric
    import axioma_io_pkg::*;
#(
    parameter int                        N_SLAVES  = 4,
    parameter int                        ADDR_W    = 6,
    parameter int                        DATA_W    = 8,
    parameter int                        N_IRQ     = 8,
    parameter int                        TIMEOUT   = 15,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLOT_BASE = 24'hC20400,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLOT_LAST = 24'hFEF7CF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    axioma_io_fabric_if.slave    bus,
    input  logic [N_IRQ-1:0]     irq_src,
    input  logic                 irq_ack,
    output logic                 irq_req,
    output logic [IRQ_VEC_W-1:0] irq_vector,
    output logic [N_IRQ-1:0]     irq_pending
);

    fsm_state_e state_q, state_d;

    logic [N_SLAVES-1:0]  hit;
    logic [N_SLAVES-1:0]  hit_onehot;
    logic                 hit_any;
    logic                 ready_sel;
    logic [DATA_W-1:0]    rdata_mux;
    logic [DATA_W-1:0]    slot_rdata [N_SLAVES];

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [N_SLAVES-1:0]  sel_q, sel_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slot
            assign hit[gi] = (bus.m_addr >= SLOT_BASE[gi*ADDR_W +: ADDR_W]) &&
                             (bus.m_addr <= SLOT_LAST[gi*ADDR_W +: ADDR_W]);
            assign slot_rdata[gi] = bus.s_rdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Isolating the lowest set bit resolves overlapping windows in favour of the lower slot.
    assign hit_onehot = hit & (~hit + N_SLAVES'(1));
    assign hit_any    = |hit;
    assign ready_sel  = |(bus.s_ready & sel_q);

    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q[i]) begin
                rdata_mux = rdata_mux | slot_rdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.m_read && bus.m_write) begin
                    state_d = ST_ERR;
                end else if (bus.m_read || bus.m_write) begin
                    state_d = hit_any ? ST_ACCESS : ST_ERR;
                end
            end
            ST_ACCESS: begin
                // s_ready on the final permitted cycle still completes the access
                if (ready_sel) begin
                    state_d = ST_DONE;
                end else if (cnt_q == TMO_CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.m_ready = 1'b0;
        bus.m_error = 1'b0;
        bus.m_rdata = '0;
        bus.s_sel   = '0;
        bus.s_read  = 1'b0;
        bus.s_write = 1'b0;
        unique case (state_q)
            ST_ACCESS: begin
                bus.s_sel   = sel_q;
                bus.s_read  = rd_q;
                bus.s_write = wr_q;
            end
            ST_DONE: begin
                bus.m_ready = 1'b1;
                bus.m_rdata = rdata_q;
            end
            ST_ERR: begin
                bus.m_ready = 1'b1;
                bus.m_error = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((bus.m_read ^ bus.m_write) && hit_any) begin
                    addr_d  = bus.m_addr;
                    wdata_d = bus.m_wdata;
                    sel_d   = hit_onehot;
                    rd_d    = bus.m_read;
                    wr_d    = bus.m_write;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                if (ready_sel) begin
                    rdata_d = rd_q ? rdata_mux : '0;
                end else begin
                    cnt_d = cnt_q + TMO_CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;

    axioma_irq_arbiter #(
        .N_IRQ (N_IRQ)
    ) u_irq (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq_src     (irq_src),
        .irq_ack     (irq_ack),
        .irq_req     (irq_req),
        .irq_vector  (irq_vector),
        .irq_pending (irq_pending)
    );

endmodule
